// File: rtl/multiplicador_seq8.sv
`default_nettype none
// ============================================================================
// multiplicador_seq8 : sequential shift-and-add unsigned multiplier reusing
//                      one somador8bit adder per iteration.  Rev 1.0
// ============================================================================

module somador8bit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
endmodule

module multiplicador_seq8 #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] P
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mc_q, mc_d;
  logic [WIDTH-1:0]     acc_h_q, acc_h_d;
  logic [WIDTH-1:0]     acc_l_q, acc_l_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 cout;

  assign addend = acc_l_q[0] ? mc_q : '0;

  somador8bit #(.WIDTH(WIDTH)) u_somador (
    .A    (acc_h_q),
    .B    (addend),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (cout)
  );

  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    acc_h_d = acc_h_q;
    acc_l_d = acc_l_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          mc_d    = A;
          acc_h_d = '0;
          acc_l_d = B;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // {Cout,Sum,ACC_L} shifted right by one: carry lands in the MSB
        acc_h_d = {cout, sum[WIDTH-1:1]};
        acc_l_d = {sum[0], acc_l_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          p_d     = {cout, sum[WIDTH-1:1], sum[0], acc_l_q[WIDTH-1:1]};
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      mc_q    <= '0;
      acc_h_q <= '0;
      acc_l_q <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      acc_h_q <= acc_h_d;
      acc_l_q <= acc_l_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign P    = p_q;
endmodule

`default_nettype wire

// File: tb/tb_multiplicador_seq8.sv
`default_nettype none
// ============================================================================
// tb_multiplicador_seq8 : directed self-checking bench for multiplicador_seq8.
//                         Rev 1.0
// ============================================================================
module tb_multiplicador_seq8;
  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  multiplicador_seq8 #(.WIDTH(8)) dut (
    .Clk   (clk),
    .Rst   (rst),
    .Start (start),
    .A     (a),
    .B     (b),
    .Busy  (busy),
    .Done  (done),
    .P     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlap++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One operation: Start accepted at edge k, Done expected after edge k+8.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input bit scramble,
                       output logic [15:0] prod);
    int n;
    int busy_cnt;
    bit got;
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    if (scramble) begin a = ~av; b = bv ^ 8'h5A; end
    check_eq("busy_after_accept", busy, 1);
    n = 0; busy_cnt = 1; got = 0;
    while (n < 20 && !got) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1;
      else if (busy) busy_cnt++;
      if (scramble && n == 3) begin a = 8'hA5; b = 8'h3C; end
    end
    check_eq("done_latency", n, 8);
    check_eq("busy_cycles", busy_cnt, 8);
    prod = p;
    @(posedge clk); #1;
    check_eq("done_pulse_width", done, 0);
    check_eq("p_holds_after_done", p, prod);
  endtask

  logic [15:0] r;
  int prev_rise, rises, last_busy, edge_i;
  int spacing_bad;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_p", p, 16'h0000);
    rst = 1'b0;

    // Directed products
    do_op(8'h00, 8'h00, 0, r); check_eq("p_00x00", r, 16'h0000);
    do_op(8'hFF, 8'hFF, 0, r); check_eq("p_FFxFF", r, 16'hFE01);
    do_op(8'h0D, 8'h0B, 1, r); check_eq("p_0Dx0B_inputs_changed", r, 16'h008F);
    do_op(8'h80, 8'h02, 0, r); check_eq("p_80x02", r, 16'h0100);
    do_op(8'h01, 8'hFF, 0, r); check_eq("p_01xFF", r, 16'h00FF);

    // Start held high: accepted only from IDLE, every 10 edges
    @(negedge clk);
    start = 1'b1; a = 8'h02; b = 8'h03;
    prev_rise = -1; rises = 0; last_busy = 0; spacing_bad = 0;
    for (edge_i = 0; edge_i < 32; edge_i++) begin
      @(posedge clk); #1;
      if (busy && !last_busy) begin
        if (prev_rise >= 0 && (edge_i - prev_rise) != 10) spacing_bad++;
        prev_rise = edge_i;
        rises++;
      end
      last_busy = busy;
    end
    check_eq("held_start_rises", rises, 4);
    check_eq("held_start_spacing", spacing_bad, 0);
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_eq("held_start_p", p, 16'h0006);

    // Reset at the 4th RUN edge
    @(negedge clk);
    start = 1'b1; a = 8'h11; b = 8'h22;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_reset_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrun_reset_busy", busy, 0);
    check_eq("midrun_reset_done", done, 0);
    check_eq("midrun_reset_p", p, 16'h0000);
    do_op(8'h03, 8'h05, 0, r); check_eq("p_after_reset_03x05", r, 16'h000F);

    // Sampled sweep against the reference product
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [7:0] av, bv;
        logic [15:0] ref_p;
        av = 8'(i * 17);
        bv = 8'(j * 17 + (i & 1));
        ref_p = 16'(av) * 16'(bv);
        do_op(av, bv, 0, r);
        check_eq("sweep_product", r, ref_p);
      end
    end

    check_eq("busy_done_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
